// File: rtl/reg_cmd_master.sv
// Command-frame initiator for the system register file.
// Decodes write frames (WR_CMD, addr, data) and read frames (RD_CMD, addr)
// arriving as byte strobes from the UART RX path. It drives single-cycle
// WrEn/RdEn pulses towards the register file and returns read data to the
// UART TX path.
//
// TX handshake: TX_Valid rises together with TX_Data and both stay frozen
// until a rising CLK edge on which TX_Valid & TX_Ready are both high. That
// edge transfers the byte, and TX_Valid is low from the next cycle on.
module reg_cmd_master #(
  parameter int                        Address_Width  = 4,
  parameter int                        Register_Width = 8,
  parameter logic [Register_Width-1:0] WR_CMD         = 8'hAA,
  parameter logic [Register_Width-1:0] RD_CMD         = 8'hBB,
  parameter int                        TIMEOUT        = 15
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [Register_Width-1:0] RX_Data,
  input  logic                      RX_Valid,
  output logic                      WrEn,
  output logic                      RdEn,
  output logic [Address_Width-1:0]  Address,
  output logic [Register_Width-1:0] WrData,
  input  logic [Register_Width-1:0] RdData,
  input  logic                      RdData_Valid,
  output logic [Register_Width-1:0] TX_Data,
  output logic                      TX_Valid,
  input  logic                      TX_Ready,
  output logic                      Busy,
  output logic                      Cmd_Error,
  output logic                      Rx_Drop,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_EXEC = 3'd3,
    RD_ADDR = 3'd4,
    RD_REQ  = 3'd5,
    RD_WAIT = 3'd6,
    TX_SEND = 3'd7
  } state_t;

  // Last RD_WAIT count before the read is abandoned.
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t                    state;
  state_t                    state_next;
  logic [3:0]                cnt;
  logic [3:0]                cnt_next;
  logic [Address_Width-1:0]  addr_next;
  logic [Register_Width-1:0] wdata_next;
  logic [Register_Width-1:0] tdata_next;
  logic                      tvalid_next;
  logic                      err_next;
  logic                      drop_next;
  logic                      addr_bad;

  // An address byte is illegal if any bit above the address field is set.
  assign addr_bad  = (RX_Data >> Address_Width) != '0;
  assign dbg_state = state;

  // State register and all registered outputs; the pulses are derived from
  // the state being entered so they line up exactly with that state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_Data   <= '0;
      TX_Valid  <= 1'b0;
      Busy      <= 1'b0;
      Cmd_Error <= 1'b0;
      Rx_Drop   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      WrEn      <= (state_next == WR_EXEC);
      RdEn      <= (state_next == RD_REQ);
      Address   <= addr_next;
      WrData    <= wdata_next;
      TX_Data   <= tdata_next;
      TX_Valid  <= tvalid_next;
      Busy      <= (state_next != IDLE);
      Cmd_Error <= err_next;
      Rx_Drop   <= drop_next;
    end
  end

  // Frame decoding, read wait/timeout and TX handshake: next state and next
  // values of the held registers.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    addr_next   = Address;
    wdata_next  = WrData;
    tdata_next  = TX_Data;
    tvalid_next = TX_Valid;
    err_next    = 1'b0;
    drop_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (RX_Valid) begin
          if (RX_Data == WR_CMD)      state_next = WR_ADDR;
          else if (RX_Data == RD_CMD) state_next = RD_ADDR;
          else                        err_next   = 1'b1;
        end
      end
      WR_ADDR, RD_ADDR: begin
        if (RX_Valid) begin
          if (addr_bad) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            addr_next  = RX_Data[Address_Width-1:0];
            state_next = (state == WR_ADDR) ? WR_DATA : RD_REQ;
          end
        end
      end
      WR_DATA: begin
        if (RX_Valid) begin
          wdata_next = RX_Data;
          state_next = WR_EXEC;
        end
      end
      WR_EXEC: begin
        drop_next  = RX_Valid;
        state_next = IDLE;
      end
      RD_REQ: begin
        // Any RdData_Valid seen here is stale and deliberately ignored.
        drop_next  = RX_Valid;
        cnt_next   = 4'd0;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        drop_next = RX_Valid;
        if (RdData_Valid) begin
          tdata_next  = RdData;
          tvalid_next = 1'b1;
          state_next  = TX_SEND;
        end else if (cnt == TO_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      TX_SEND: begin
        drop_next = RX_Valid;
        if (TX_Ready) begin
          tvalid_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_cmd_master.sv
// Self-checking bench for reg_cmd_master: directed multi-cycle sequences,
// a table of whole frames, and random frames scored against a frame-level
// reference model.
module tb_reg_cmd_master;

  logic       CLK;
  logic       RST;
  logic [7:0] RX_Data;
  logic       RX_Valid;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic [7:0] TX_Data;
  logic       TX_Valid;
  logic       TX_Ready;
  logic       Busy;
  logic       Cmd_Error;
  logic       Rx_Drop;
  logic [2:0] dbg_state;

  reg_cmd_master dut (
    .CLK(CLK), .RST(RST), .RX_Data(RX_Data), .RX_Valid(RX_Valid),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .TX_Data(TX_Data), .TX_Valid(TX_Valid), .TX_Ready(TX_Ready),
    .Busy(Busy), .Cmd_Error(Cmd_Error), .Rx_Drop(Rx_Drop),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  int         err_seen = 0;
  logic [11:0] exp_wr_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  model_regs[16];
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;

  int   rd_lat;
  bit   ready_rand;
  logic tx_ready_force;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- register file responder ----------------
  logic [7:0] rf[16];
  int         pend;
  logic [7:0] resp;
  initial begin
    RdData_Valid = 1'b0;
    RdData = 8'h00;
    pend = 0;
    resp = 8'h00;
    for (int i = 0; i < 16; i++) rf[i] = init_val(i);
    forever begin
      @(posedge CLK); #1;
      RdData_Valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          RdData_Valid = 1'b1;
          RdData = resp;
        end
      end
      if (RdEn && rd_lat > 0) begin
        pend = rd_lat;
        resp = rf[Address];
      end
      if (WrEn) rf[Address] = WrData;
    end
  end

  // ---------------- TX ready driver ----------------
  initial begin
    TX_Ready = 1'b0;
    forever begin
      @(posedge CLK); #2;
      TX_Ready = ready_rand ? 1'($urandom_range(0, 1)) : tx_ready_force;
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge CLK) begin
    if (WrEn || RdEn) begin
      check("wr_rd_exclusive", 32'(WrEn & RdEn), 32'(0));
      check("no_double_pulse", 32'((WrEn & prev_wr) | (RdEn & prev_rd)), 32'(0));
    end
    prev_wr = WrEn;
    prev_rd = RdEn;
    if (WrEn) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_event: got write %0h, required no write", {Address, WrData});
      end else begin
        check("wr_event", 32'({Address, WrData}), 32'(exp_wr_q.pop_front()));
      end
    end
    if (TX_Valid && TX_Ready) begin
      if (exp_tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_event: got tx byte %0h, required no tx", TX_Data);
      end else begin
        check("tx_event", 32'(TX_Data), 32'(exp_tx_q.pop_front()));
      end
    end
    if (Cmd_Error) err_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_Data = b;
    RX_Valid = 1'b1;
    tick();
    RX_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (Busy && n < 300) begin
      tick();
      n++;
    end
    check("wait_idle_busy", 32'(Busy), 32'(0));
    tick();
  endtask

  // Frame-level reference: decode a complete frame from the protocol rules.
  task automatic model_frame(input logic [7:0] fb[$], input bit responds, output int exp_err);
    logic [7:0] op;
    logic [7:0] ab;
    logic [7:0] db;
    op = fb[0];
    ab = (fb.size() > 1) ? fb[1] : 8'h00;
    db = (fb.size() > 2) ? fb[2] : 8'h00;
    exp_err = 0;
    if (op != 8'hAA && op != 8'hBB) exp_err = 1;
    else if (ab > 8'd15) exp_err = 1;
    else if (op == 8'hAA) begin
      model_regs[ab[3:0]] = db;
      exp_wr_q.push_back({ab[3:0], db});
    end else if (!responds) exp_err = 1;
    else exp_tx_q.push_back(model_regs[ab[3:0]]);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic       exp_wr;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       exp_tx;
    logic [7:0] td;
    logic       exp_err;
  } vec_t;

  vec_t vt[10];

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int err0;
    vt[0] = '{8'hAA, 8'h06, 8'h5A, 3, 1'b1, 4'h6, 8'h5A, 1'b0, 8'h00, 1'b0};
    vt[1] = '{8'hBB, 8'h06, 8'h00, 2, 1'b0, 4'h0, 8'h00, 1'b1, 8'h5A, 1'b0};
    vt[2] = '{8'h12, 8'h00, 8'h00, 1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1};
    vt[3] = '{8'hAA, 8'h10, 8'h00, 2, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1};
    vt[4] = '{8'hBB, 8'hF3, 8'h00, 2, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1};
    vt[5] = '{8'hAA, 8'h0F, 8'hFF, 3, 1'b1, 4'hF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vt[6] = '{8'hBB, 8'h0F, 8'h00, 2, 1'b0, 4'h0, 8'h00, 1'b1, 8'hFF, 1'b0};
    vt[7] = '{8'hAA, 8'h00, 8'h00, 3, 1'b1, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[8] = '{8'hBB, 8'h00, 8'h00, 2, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b0};
    vt[9] = '{8'h00, 8'h00, 8'h00, 1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1};

    RST = 1'b1;
    RX_Valid = 1'b0;
    RX_Data = 8'h00;
    tx_ready_force = 1'b0;
    ready_rand = 1'b0;
    rd_lat = 1;
    for (int i = 0; i < 16; i++) model_regs[i] = init_val(i);

    // Power-on reset.
    idle(3);
    check("reset_outputs", 32'({WrEn, RdEn, Address, WrData, TX_Data, TX_Valid,
                                Busy, Cmd_Error, Rx_Drop, dbg_state}), 32'(0));
    RST = 1'b0;
    tick();
    check("idle_after_reset", 32'({Busy, dbg_state}), 32'(0));

    // Write frame: WrEn one cycle after the data strobe.
    exp_wr_q.push_back({4'h5, 8'h3C});
    model_regs[5] = 8'h3C;
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    check("wr_pulse", 32'({WrEn, RdEn, Address, WrData}), 32'({1'b1, 1'b0, 4'h5, 8'h3C}));
    tick();
    check("wr_single", 32'({WrEn, RdEn, Busy}), 32'(0));
    check("addr_hold", 32'({Address, WrData}), 32'({4'h5, 8'h3C}));

    // Read with stalled TX, plus an opcode dropped during TX_SEND.
    exp_wr_q.push_back({4'h2, 8'h81});
    model_regs[2] = 8'h81;
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h81);
    tick();
    send_byte(8'hBB);
    send_byte(8'h02);
    check("rd_pulse", 32'({RdEn, WrEn, Address}), 32'({1'b1, 1'b0, 4'h2}));
    tick();
    check("rd_single", 32'(RdEn), 32'(0));
    tick();
    check("tx_first", 32'({TX_Valid, TX_Data}), 32'({1'b1, 8'h81}));
    exp_tx_q.push_back(8'h81);
    send_byte(8'hAA);
    check("rx_drop_tx_send", 32'({Rx_Drop, TX_Valid, TX_Data}), 32'({1'b1, 1'b1, 8'h81}));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tx_hold", 32'({TX_Valid, TX_Data, Busy}), 32'({1'b1, 8'h81, 1'b1}));
    end
    tx_ready_force = 1'b1;
    tick();
    tx_ready_force = 1'b0;
    check("tx_done_idle", 32'({TX_Valid, Busy, dbg_state}), 32'(0));
    idle(2);

    // Back-to-back frames; a byte landing in WR_EXEC is dropped.
    exp_wr_q.push_back({4'h3, 8'h07});
    model_regs[3] = 8'h07;
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h07);
    send_byte(8'hBB);
    check("rx_drop_wr_exec", 32'({Rx_Drop, dbg_state}), 32'({1'b1, 3'd0}));
    exp_tx_q.push_back(8'h07);
    tx_ready_force = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h03);
    wait_idle();
    check("b2b_queues", 32'(exp_wr_q.size() + exp_tx_q.size()), 32'(0));

    // Read timeout: error pulse after 15 RD_WAIT cycles.
    rd_lat = 0;
    send_byte(8'hBB);
    send_byte(8'h01);
    n = 0;
    while (!Cmd_Error && n < 40) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(16));
    check("timeout_idle", 32'({Busy, dbg_state}), 32'(0));
    tick();
    check("err_single", 32'(Cmd_Error), 32'(0));
    rd_lat = 3;

    // Reset in the middle of a read.
    send_byte(8'hBB);
    send_byte(8'h01);
    check("rd_before_reset", 32'(RdEn), 32'(1));
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    check("reset_mid_read", 32'({WrEn, RdEn, Address, WrData, TX_Data, TX_Valid,
                                 Busy, Cmd_Error, Rx_Drop, dbg_state}), 32'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_tx_after_reset", 32'({TX_Valid, Busy}), 32'(0));
    end
    rd_lat = 1;

    // Table of whole frames.
    for (int v = 0; v < 10; v++) begin
      if (vt[v].exp_wr) begin
        exp_wr_q.push_back({vt[v].wa, vt[v].wd});
        model_regs[vt[v].wa] = vt[v].wd;
      end
      if (vt[v].exp_tx) exp_tx_q.push_back(vt[v].td);
      err0 = err_seen;
      send_byte(vt[v].b0);
      if (vt[v].n > 1) begin idle(1); send_byte(vt[v].b1); end
      if (vt[v].n > 2) begin idle(1); send_byte(vt[v].b2); end
      wait_idle();
      check("vec_err", 32'(err_seen - err0), 32'(vt[v].exp_err));
      check("vec_queues", 32'(exp_wr_q.size() + exp_tx_q.size()), 32'(0));
    end

    // Random frames against the frame-level model.
    tx_ready_force = 1'b0;
    ready_rand = 1'b1;
    for (int f = 0; f < 80; f++) begin
      logic [7:0] fb[$];
      logic [7:0] op;
      int kind;
      int exp_err;
      fb = {};
      kind = $urandom_range(0, 4);
      rd_lat = (kind == 4) ? 0 : $urandom_range(1, 4);
      case (kind)
        0: fb = {8'hAA, 8'($urandom_range(0, 15)), 8'($urandom)};
        1, 4: fb = {8'hBB, 8'($urandom_range(0, 15))};
        2: begin
          do op = 8'($urandom); while (op == 8'hAA || op == 8'hBB);
          fb = {op};
        end
        default: fb = {($urandom_range(0, 1) == 1) ? 8'hAA : 8'hBB,
                       {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))}};
      endcase
      model_frame(fb, rd_lat > 0, exp_err);
      err0 = err_seen;
      for (int i = 0; i < fb.size(); i++) begin
        if (i > 0) idle($urandom_range(0, 2));
        send_byte(fb[i]);
      end
      wait_idle();
      check("rand_err", 32'(err_seen - err0), 32'(exp_err));
      check("rand_queues", 32'(exp_wr_q.size() + exp_tx_q.size()), 32'(0));
    end
    ready_rand = 1'b0;
    idle(3);

    check("final_queues", 32'(exp_wr_q.size() + exp_tx_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
